// File: rtl/vga_timing_gen.sv
// VGA 640x480@60 timing generator with a centred 512x480 1-bpp framebuffer.
// Two-stage pipeline: counters -> registered RAM address -> registered pixel.
// Sync and window flags travel alongside so every output refers to the same
// screen position, two clocks after the counters reached it.
`timescale 1ns/1ps

module vga_timing_gen #(
    // Vertical timing is exposed so a shortened frame can be built for bring-up;
    // the defaults give the standard 525-line frame.
    parameter int unsigned VVisible = 480,
    parameter int unsigned VFront   = 10,
    parameter int unsigned VSync    = 2,
    parameter int unsigned VBack    = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read_data,
    output logic [17:0] read_addr,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b,
    output logic        hs,
    output logic        vs,
    output logic        swap
);

    // Horizontal geometry is fixed: the window arithmetic below relies on it.
    localparam logic [9:0] HLast      = 10'd799;
    localparam logic [9:0] HSyncStart = 10'd656;
    localparam logic [9:0] HSyncEnd   = 10'd752;
    localparam logic [9:0] WinStart   = 10'd64;
    localparam logic [9:0] WinEnd     = 10'd576;

    localparam logic [9:0] VVis       = 10'(VVisible);
    localparam logic [9:0] VSyncStart = 10'(VVisible + VFront);
    localparam logic [9:0] VSyncEnd   = 10'(VVisible + VFront + VSync);
    localparam logic [9:0] VLast      = 10'(VVisible + VFront + VSync + VBack - 1);

    logic [9:0] h;
    logic [9:0] v;

    logic       in_win;
    logic       hs_raw;
    logic       vs_raw;
    logic [8:0] fb_x;

    // First pipeline stage flags, aligned with read_addr
    logic       win_s1;
    logic       hs_s1;
    logic       vs_s1;

    // Decode the current counter position
    always_comb begin
        in_win = (h >= WinStart) && (h < WinEnd) && (v < VVis);
        hs_raw = !((h >= HSyncStart) && (h < HSyncEnd));
        vs_raw = !((v >= VSyncStart) && (v < VSyncEnd));
        // Modulo-512 subtraction: columns 64..575 map onto 0..511
        fb_x   = h[8:0] - 9'd64;
    end

    // Horizontal and vertical position counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h <= '0;
            v <= '0;
        end else if (h == HLast) begin
            h <= '0;
            v <= (v == VLast) ? '0 : v + 10'd1;
        end else begin
            h <= h + 10'd1;
        end
    end

    // Stage 1: issue the framebuffer read and carry the position flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_addr <= '0;
            win_s1    <= 1'b0;
            hs_s1     <= 1'b1;
            vs_s1     <= 1'b1;
            swap      <= 1'b0;
        end else begin
            // Outside the window the address is don't-care; the pixel is masked
            read_addr <= {v[8:0], fb_x};
            win_s1    <= in_win;
            hs_s1     <= hs_raw;
            vs_s1     <= vs_raw;
            swap      <= (h == 10'd0) && (v == VVis);
        end
    end

    // Stage 2: register colour from the RAM data and the aligned sync levels
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r  <= 4'h0;
            g  <= 4'h0;
            b  <= 4'h0;
            hs <= 1'b1;
            vs <= 1'b1;
        end else begin
            r  <= {4{win_s1 & read_data}};
            g  <= {4{win_s1 & read_data}};
            b  <= {4{win_s1 & read_data}};
            hs <= hs_s1;
            vs <= vs_s1;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen. A full-size instance covers the
// horizontal timing, window and address mapping; a second instance with a
// 15-line frame covers vsync, frame strobe period and mid-frame reset.
`timescale 1ns/1ps

module tb_vga_timing_gen;

    localparam logic [32:0] MaskAll    = 33'h1_FFFF_FFFF;
    localparam logic [32:0] MaskNoAddr = 33'h0_0000_7FFF;
    localparam logic [32:0] MaskAddr   = 33'h1_FFFF_8000;
    localparam logic [32:0] MaskRgb    = 33'h0_0000_7FF8;
    localparam logic [32:0] MaskHs     = 33'h0_0000_0004;
    localparam logic [32:0] MaskVs     = 33'h0_0000_0002;
    localparam logic [32:0] MaskSwap   = 33'h0_0000_0001;
    // addr=0, rgb=0, hs=1, vs=1, swap=0
    localparam logic [32:0] IdleVal    = 33'h0_0000_0006;

    typedef struct {
        int unsigned due;
        bit          inst;
        logic [32:0] mask;
        logic [32:0] exp;
        string       name;
    } vec_t;

    vec_t sb[$];

    logic clk;
    logic rst;
    logic rst_s;
    logic one_mode;

    logic        read_data;
    logic [17:0] read_addr;
    logic [3:0]  r, g, b;
    logic        hs, vs, swap;

    logic        read_data_s;
    logic [17:0] read_addr_s;
    logic [3:0]  r_s, g_s, b_s;
    logic        hs_s, vs_s, swap_s;

    logic [32:0] obs;
    logic [32:0] obs_s;

    int unsigned cyc = 0;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned rel;
    int unsigned rel2;
    int unsigned rel3;

    vga_timing_gen dut (
        .clk       (clk),
        .rst       (rst),
        .read_data (read_data),
        .read_addr (read_addr),
        .r         (r),
        .g         (g),
        .b         (b),
        .hs        (hs),
        .vs        (vs),
        .swap      (swap)
    );

    vga_timing_gen #(
        .VVisible (8),
        .VFront   (2),
        .VSync    (2),
        .VBack    (3)
    ) dut_s (
        .clk       (clk),
        .rst       (rst_s),
        .read_data (read_data_s),
        .read_addr (read_addr_s),
        .r         (r_s),
        .g         (g_s),
        .b         (b_s),
        .hs        (hs_s),
        .vs        (vs_s),
        .swap      (swap_s)
    );

    // Framebuffer model: data answers the address registered last cycle
    assign read_data   = one_mode ? 1'b1 : ^read_addr;
    assign read_data_s = ^read_addr_s;

    assign obs   = {read_addr, r, g, b, hs, vs, swap};
    assign obs_s = {read_addr_s, r_s, g_s, b_s, hs_s, vs_s, swap_s};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [32:0] f_rgb(input logic [3:0] c);
        return {18'd0, c, c, c, 3'b000};
    endfunction

    function automatic logic [32:0] f_addr(input logic [17:0] a);
        return {a, 15'd0};
    endfunction

    task automatic expect_at(input int unsigned due, input bit inst, input logic [32:0] mask,
                             input logic [32:0] exp, input string name);
        vec_t e;
        e.due  = due;
        e.inst = inst;
        e.mask = mask;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic rgb_at(input int unsigned due, input bit inst, input logic [3:0] c,
                          input string name);
        expect_at(due, inst, MaskRgb, f_rgb(c), name);
    endtask

    // Monitor: compares whatever is due at this falling edge
    initial begin
        vec_t        e;
        logic [32:0] act;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e   = sb.pop_front();
                act = e.inst ? obs_s : obs;
                n_vec++;
                if (e.due != cyc) begin
                    n_err++;
                    $display("FAIL %s: check due at cycle %0d reached only at %0d",
                             e.name, e.due, cyc);
                end else if ((act & e.mask) !== (e.exp & e.mask)) begin
                    n_err++;
                    $display("FAIL %s: cycle %0d got %h required %h (mask %h)",
                             e.name, cyc, act & e.mask, e.exp & e.mask, e.mask);
                end
            end
        end
    end

    task automatic wait_cyc(input int unsigned target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        rst_s    = 1'b1;
        one_mode = 1'b0;

        expect_at(3, 1'b0, MaskAll, IdleVal, "reset_state_full");
        expect_at(3, 1'b1, MaskAll, IdleVal, "reset_state_small");

        wait_cyc(4);
        rst = 1'b0;
        rel = cyc;

        // Full-size instance; position (h,v) shows at rel + v*800 + h + 2
        expect_at(rel + 2, 1'b0, MaskNoAddr, IdleVal, "first_pixel_0_0");
        rgb_at(rel + 65,   1'b0, 4'h0, "col63_border");
        rgb_at(rel + 66,   1'b0, 4'h0, "fb_0_0_parity0");
        rgb_at(rel + 67,   1'b0, 4'hF, "fb_1_0_parity1");
        rgb_at(rel + 68,   1'b0, 4'hF, "fb_2_0_parity1");
        rgb_at(rel + 69,   1'b0, 4'h0, "fb_3_0_parity0");
        rgb_at(rel + 577,  1'b0, 4'hF, "fb_511_0_parity1");
        rgb_at(rel + 578,  1'b0, 4'h0, "col576_border");
        expect_at(rel + 657,  1'b0, MaskHs, 33'h4, "hs_high_655");
        expect_at(rel + 658,  1'b0, MaskHs, 33'h0, "hs_low_656");
        expect_at(rel + 753,  1'b0, MaskHs, 33'h0, "hs_low_751");
        expect_at(rel + 754,  1'b0, MaskHs, 33'h4, "hs_high_752");
        rgb_at(rel + 866,  1'b0, 4'hF, "fb_0_1_parity1");
        expect_at(rel + 1458, 1'b0, MaskHs, 33'h0, "hs_low_656_line1");
        expect_at(rel + 1554, 1'b0, MaskHs, 33'h4, "hs_high_752_line1");
        expect_at(rel + 2470, 1'b0, MaskAddr, f_addr(18'd1541), "addr_69_3");
        rgb_at(rel + 2471, 1'b0, 4'h0, "fb_5_3_parity0");
        rgb_at(rel + 2473, 1'b0, 4'hF, "fb_7_3_parity1");
        // read_data tied high from line 5 onwards
        rgb_at(rel + 4065, 1'b0, 4'h0, "tie1_col63");
        rgb_at(rel + 4066, 1'b0, 4'hF, "tie1_col64");
        rgb_at(rel + 4577, 1'b0, 4'hF, "tie1_col575");
        rgb_at(rel + 4578, 1'b0, 4'h0, "tie1_col576");
        rgb_at(rel + 4642, 1'b0, 4'h0, "tie1_hblank");
        expect_at(rel + 4702, 1'b0, MaskHs, 33'h0, "hs_low_line5");

        // Switch the RAM model during horizontal blanking of line 4
        wait_cyc(rel + 3900);
        one_mode = 1'b1;
        wait_cyc(rel + 4710);
        drain();

        // Short-frame instance: 15 lines, visible 0-7, vsync lines 10-11
        @(negedge clk);
        rst_s = 1'b0;
        rel2  = cyc;
        expect_at(rel2 + 2,     1'b1, MaskNoAddr, IdleVal, "s_first_pixel");
        rgb_at(rel2 + 67,       1'b1, 4'hF, "s_fb_1_0");
        rgb_at(rel2 + 5666,     1'b1, 4'hF, "s_fb_0_7_parity1");
        expect_at(rel2 + 6176,  1'b1, MaskAddr, f_addr(18'd4095), "s_addr_575_7");
        expect_at(rel2 + 6400,  1'b1, MaskSwap, 33'h0, "s_swap_before");
        expect_at(rel2 + 6401,  1'b1, MaskSwap, 33'h1, "s_swap_pulse");
        expect_at(rel2 + 6402,  1'b1, MaskSwap, 33'h0, "s_swap_after");
        rgb_at(rel2 + 6466,     1'b1, 4'h0, "s_vblank_col64");
        expect_at(rel2 + 8001,  1'b1, MaskVs, 33'h2, "s_vs_high_line9");
        expect_at(rel2 + 8002,  1'b1, MaskVs, 33'h0, "s_vs_low_line10");
        expect_at(rel2 + 9601,  1'b1, MaskVs, 33'h0, "s_vs_low_line11");
        expect_at(rel2 + 9602,  1'b1, MaskVs, 33'h2, "s_vs_high_line12");
        expect_at(rel2 + 18400, 1'b1, MaskSwap, 33'h0, "s_swap2_before");
        expect_at(rel2 + 18401, 1'b1, MaskSwap, 33'h1, "s_swap2_pulse");
        expect_at(rel2 + 18402, 1'b1, MaskSwap, 33'h0, "s_swap2_after");
        wait_cyc(rel2 + 18410);
        drain();

        // Mid-frame reset during hsync; outputs must clear before any clock edge
        wait_cyc(rel2 + 28699);
        @(posedge clk);
        #2;
        rst_s = 1'b1;
        expect_at(cyc, 1'b1, MaskAll, IdleVal, "s_async_reset");
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_s = 1'b0;
        rel3  = cyc;
        expect_at(rel3 + 1,    1'b1, MaskNoAddr, IdleVal, "s_post_reset_idle");
        expect_at(rel3 + 2,    1'b1, MaskNoAddr, IdleVal, "s_post_reset_0_0");
        expect_at(rel3 + 6400, 1'b1, MaskSwap, 33'h0, "s_post_reset_no_swap");
        expect_at(rel3 + 6401, 1'b1, MaskSwap, 33'h1, "s_post_reset_swap");
        expect_at(rel3 + 6402, 1'b1, MaskSwap, 33'h0, "s_post_reset_swap_end");
        wait_cyc(rel3 + 6410);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
